seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder. It holds a multi-digit display value and steps through the digits one at a time. For each digit it presents that digit's nibble to the shared decoder, then drives that digit's active-low enable. A guard gap between digits prevents ghosting. Display updates are double-buffered so a new value only takes effect at a frame boundary, which avoids tearing.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_DIV, 50000, clock cycles each digit is driven per frame (>=1)
GUARD_CYCLES, 2, all-off cycles before each digit's drive slot (>=0; 0 means no guard state)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low forces the display dark and holds the scan at its start
value_in  in  4*NUM_DIGITS  display value; nibble i belongs to digit i, digit 0 is least significant
load  in  1  single-cycle strobe that captures value_in into the pending buffer
blank_mask  in  NUM_DIGITS  bit i=1 keeps digit i dark during its slot
nibble_out  out  4  nibble for the shared hex decoder
digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one bit low at a time
frame_done  out  1  one-cycle pulse at the end of each complete frame

Behaviour:
- Reset (async, rst_n low):
  - state=GUARD, digit_idx=0, div_cnt=0.
  - active=0, pending=0, pend_flag=0.
  - nibble_out=0, digit_en_n=all 1, frame_done=0.
- All outputs are registered.
- States:
  - GUARD: lasts GUARD_CYCLES cycles; digit_en_n all 1; nibble_out = active[4*digit_idx +: 4].
  - DRIVE: lasts REFRESH_DIV cycles; digit_en_n has bit digit_idx low, unless blank_mask[digit_idx]=1, in which case all bits are 1 and timing is unchanged.
- Transitions:
  - GUARD -> DRIVE when div_cnt reaches GUARD_CYCLES-1.
  - DRIVE -> GUARD on the next digit when div_cnt reaches REFRESH_DIV-1.
  - div_cnt clears on every state change.
  - If GUARD_CYCLES=0, DRIVE chains directly to DRIVE of the next digit.
- nibble_out is updated on the edge that enters the digit's slot, so it is stable for the whole guard time before the enable asserts.
- Frame boundary is the edge that ends the DRIVE of digit NUM_DIGITS-1. On that edge:
  - digit_idx wraps to 0;
  - frame_done is high for the following cycle only;
  - if pend_flag=1, active <= pending and pend_flag is cleared.
- Frame period = NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles.
- load:
  - pending <= value_in and pend_flag <= 1.
  - Multiple loads within one frame: the last one wins.
  - load on the frame-boundary edge: active <= value_in directly, pend_flag ends at 0.
- blank_mask is sampled every cycle; a change takes effect on the next edge, even mid-slot.
- en=0: on the next edge, digit_en_n=all 1, state=GUARD, digit_idx=0, div_cnt=0, and no frame_done pulse. load and the buffers still operate. When en rises again, a new frame starts from GUARD of digit 0.
- Reset mid-frame: everything returns to reset values immediately, including the pending buffer.
- Sizing: div_cnt width = clog2(max(REFRESH_DIV, GUARD_CYCLES, 2)); digit_idx width = clog2(max(NUM_DIGITS, 2)).

Optional Feature:
Macro: LEADING_ZERO_SUPPRESS_EN
- Defined: digit i is also kept dark during its slot if i>0 and active nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed by this rule. The result is ORed with blank_mask; timing is unchanged.
- Undefined: only blank_mask blanks digits; no zero-detect logic is present.

Test Plan:
Common setup: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
1. Reset, then en=1 -> digit_en_n=1111 for cycle 0; 1110 for cycles 1-4; 1111 at cycle 5; 1101 for cycles 6-9. frame_done pulses at cycle 20, then every 20 cycles.
2. load=1 with value_in=16'h1A2F mid-frame -> current frame shows old digits. Next frame nibble_out per slot = F,2,A,1.
3. blank_mask=4'b0100 -> digit 2 slot shows digit_en_n=1111 for 4 cycles; frame period stays 20; other digits unaffected.
4. load 16'h1111 then load 16'h2222 in the same frame -> next frame shows all 2s. A load of 16'h3333 on the frame-boundary edge -> the immediately following frame shows all 3s.
5. en dropped during digit 2 DRIVE -> next cycle digit_en_n=1111 and no frame_done. en raised -> 1 guard cycle, then digit_en_n=1110.
6. With LEADING_ZERO_SUPPRESS_EN: 16'h00A0 -> digits 3 and 2 dark, digits 1 and 0 driven. 16'h0000 -> only digit 0 driven (nibble 0).

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus bundle for seg_scan_ctrl: display value/load/blank controls in, scan outputs and debug state out.
// load is a fire-and-forget strobe: every cycle it is high is a transfer, and there is no ready.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nibble_out;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    frame_done;
  logic                    dbg_state;

  modport master (
    output en, value_in, load, blank_mask,
    input  nibble_out, digit_en_n, frame_done, dbg_state
  );

  modport slave (
    input  en, value_in, load, blank_mask,
    output nibble_out, digit_en_n, frame_done, dbg_state
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with guard gaps and frame-aligned double buffering.
// Optional macro LEADING_ZERO_SUPPRESS_EN darkens leading zero digits (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int CNT_SPAN  = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_RANGE = (CNT_SPAN < 2) ? 2 : CNT_SPAN;
  localparam int CW        = $clog2(CNT_RANGE);
  localparam int IW        = $clog2((NUM_DIGITS < 2) ? 2 : NUM_DIGITS);
  localparam int DW        = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   digit_idx, idx_nx;
  logic [CW-1:0]   div_cnt, cnt_nx;
  logic [DW-1:0]   active, active_nx;
  logic [DW-1:0]   pending, pending_nx;
  logic            pend_flag, pend_nx;
  logic            boundary;
  logic [NUM_DIGITS-1:0] dark_mask;
  logic [3:0]            nibble_nx;
  logic [NUM_DIGITS-1:0] en_n_nx;
  logic [3:0]            nibble_q;
  logic [NUM_DIGITS-1:0] en_n_q;
  logic                  frame_done_q;

  // Scan sequencing; a low en parks the scan at GUARD of digit 0.
  always_comb begin
    state_nx = state;
    idx_nx   = digit_idx;
    cnt_nx   = div_cnt + 1'b1;
    boundary = 1'b0;
    if (!bus.en) begin
      state_nx = ST_GUARD;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_GUARD: begin
          if (div_cnt == GUARD_LAST) begin
            state_nx = ST_DRIVE;
            cnt_nx   = '0;
          end
        end
        ST_DRIVE: begin
          if (div_cnt == DRIVE_LAST) begin
            cnt_nx   = '0;
            state_nx = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_GUARD;
            if (digit_idx == IDX_LAST) begin
              idx_nx   = '0;
              boundary = 1'b1;
            end else begin
              idx_nx = digit_idx + 1'b1;
            end
          end
        end
        default: begin
          state_nx = ST_GUARD;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // A load on the boundary edge bypasses the pending buffer.
  always_comb begin
    active_nx  = active;
    pending_nx = pending;
    pend_nx    = pend_flag;
    if (boundary) begin
      if (bus.load) begin
        active_nx  = bus.value_in;
        pending_nx = bus.value_in;
      end else if (pend_flag) begin
        active_nx = pending;
      end
      pend_nx = 1'b0;
    end else if (bus.load) begin
      pending_nx = bus.value_in;
      pend_nx    = 1'b1;
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (active_nx[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  assign dark_mask = bus.blank_mask | lz_mask;
`else
  assign dark_mask = bus.blank_mask;
`endif

  // Outputs are computed from next-state values so they are registered with the state.
  always_comb begin
    nibble_nx = active_nx[{idx_nx, 2'b00} +: 4];
    en_n_nx   = '1;
    if (state_nx == ST_DRIVE && !dark_mask[idx_nx]) begin
      en_n_nx = ~(NUM_DIGITS'(1) << idx_nx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GUARD;
      digit_idx    <= '0;
      div_cnt      <= '0;
      active       <= '0;
      pending      <= '0;
      pend_flag    <= 1'b0;
      nibble_q     <= 4'h0;
      en_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      digit_idx    <= idx_nx;
      div_cnt      <= cnt_nx;
      active       <= active_nx;
      pending      <= pending_nx;
      pend_flag    <= pend_nx;
      nibble_q     <= nibble_nx;
      en_n_q       <= en_n_nx;
      frame_done_q <= boundary;
    end
  end

  assign bus.nibble_out = nibble_q;
  assign bus.digit_en_n = en_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle drive slots and a 1-cycle guard (20-cycle frame).
module tb_seg_scan_ctrl;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [3:0] exp_q[$];

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lz_of(input logic [15:0] v);
    logic [3:0] m;
    bit         z;
    m = 4'b0000;
    z = 1'b1;
`ifdef LEADING_ZERO_SUPPRESS_EN
    for (int i = 3; i > 0; i--) begin
      z    = z & (v[4*i +: 4] == 4'h0);
      m[i] = z;
    end
`endif
    return m;
  endfunction

  // Checks one 20-cycle frame starting at its first cycle; optional loads during cycles pa/pb.
  task automatic check_frame(input logic [15:0] val, input logic [3:0] blank, input logic fd0,
                             input int pa, input logic [15:0] va, input int pb, input logic [15:0] vb);
    logic [3:0] dark;
    logic [3:0] cur_nib;
    logic [3:0] e;
    int slot;
    int off;
    dark    = blank | lz_of(val);
    cur_nib = 4'h0;
    for (int d = 0; d < 4; d++) exp_q.push_back(val[4*d +: 4]);
    for (int p = 0; p < 20; p++) begin
      slot = p / 5;
      off  = p % 5;
      if (off == 0) cur_nib = exp_q.pop_front();
      e = 4'hF;
      if (off != 0 && !dark[slot]) e = ~(4'b0001 << slot);
      check($sformatf("digit_en_n p%0d", p), 32'(bus.digit_en_n), 32'(e));
      check($sformatf("nibble p%0d", p), 32'(bus.nibble_out), 32'(cur_nib));
      check($sformatf("frame_done p%0d", p), 32'(bus.frame_done), (p == 0) ? 32'(fd0) : 32'd0);
      check($sformatf("state p%0d", p), 32'(bus.dbg_state), (off == 0) ? 32'd0 : 32'd1);
      bus.load = (p == pa) || (p == pb);
      if (p == pa) bus.value_in = va;
      else if (p == pb) bus.value_in = vb;
      step();
    end
    bus.load = 1'b0;
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rst_n             = 1'b0;
    bus.en            = 1'b0;
    bus.load          = 1'b0;
    bus.value_in      = 16'h0000;
    bus.blank_mask    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst digit_en_n", 32'(bus.digit_en_n), 32'hF);
    check("rst nibble", 32'(bus.nibble_out), 32'h0);
    check("rst frame_done", 32'(bus.frame_done), 32'h0);
    check("rst state", 32'(bus.dbg_state), 32'h0);

    @(negedge clk);
    bus.en = 1'b1;
    rst_n  = 1'b1;
    // basic timing, then a mid-frame load that waits for the boundary
    check_frame(16'h0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);
    check_frame(16'h0000, 4'b0000, 1'b1, 7, 16'h1A2F, -1, 16'h0);
    check_frame(16'h1A2F, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

    // blanking one digit keeps frame timing
    bus.blank_mask = 4'b0100;
    check_frame(16'h1A2F, 4'b0100, 1'b1, -1, 16'h0, -1, 16'h0);
    bus.blank_mask = 4'b0000;

    // last load wins; a boundary-edge load applies immediately
    check_frame(16'h1A2F, 4'b0000, 1'b1, 3, 16'h1111, 9, 16'h2222);
    check_frame(16'h2222, 4'b0000, 1'b1, 19, 16'h3333, -1, 16'h0);
    check_frame(16'h3333, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

    // drop en during digit 2 drive
    repeat (11) step();
    check("digit2 drive before en drop", 32'(bus.digit_en_n), 32'hB);
    bus.en = 1'b0;
    step();
    check("en drop digit_en_n", 32'(bus.digit_en_n), 32'hF);
    check("en drop state", 32'(bus.dbg_state), 32'h0);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("en low frame_done c%0d", i), 32'(bus.frame_done), 32'h0);
      check($sformatf("en low digit_en_n c%0d", i), 32'(bus.digit_en_n), 32'hF);
      step();
    end
    bus.en = 1'b1;
    check_frame(16'h3333, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);

    // leading zero patterns (dark only when the suppression build is used)
    check_frame(16'h3333, 4'b0000, 1'b1, 19, 16'h00A0, -1, 16'h0);
    check_frame(16'h00A0, 4'b0000, 1'b1, 19, 16'h0000, -1, 16'h0);
    check_frame(16'h0000, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

    // asynchronous reset mid-frame clears the pending buffer too
    repeat (5) step();
    bus.value_in = 16'h1234;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst digit_en_n", 32'(bus.digit_en_n), 32'hF);
    check("async rst nibble", 32'(bus.nibble_out), 32'h0);
    check("async rst state", 32'(bus.dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0);
    check_frame(16'h0000, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
